// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: DEPTH-entry circular buffer of {pc, inst}.
// Latency: an entry pushed at edge N is visible on out_* after edge N; there is no bypass when empty.
// Backpressure: in_ready low when full (fetch freezes); out_valid low when empty; flush empties in one cycle.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   flush                 discard every buffered entry (taken branch); overrides push/pop
//   in_valid/in_pc/in_inst/in_ready     fetch side, push = in_valid & in_ready
//   out_valid/out_pc/out_inst/out_ready decode side, pop = out_valid & out_ready
//   count                 number of stored entries (0..DEPTH)
module inst_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  entry_t          head;

  // Handshake flags are purely functions of the stored count, so there is
  // no combinational path from in_valid or out_ready back to either.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Gate the head entry so decode never sees stale storage contents.
  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head.pc   : '0;
  assign out_inst = out_valid ? head.inst : '0;

  // Pointer and occupancy state. Flush wins over any push/pop in the same
  // cycle, so the wrong-path entry fetch presents alongside flush is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: out_* are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

endmodule
